// File: rtl/gray_pkg.sv
// Shared definitions for Gray-code sources and checkers: FSM encoding and
// a width-independent Gray-to-binary decode.
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      TRACK = 2'b01,
      LOST  = 2'b10
   } state_t;

   localparam int GRAY_MAX_W = 64;

   // Zero-extended inputs decode correctly at any width: the prefix XOR runs
   // from the MSB down, so leading zeros leave the low bits untouched.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_nbits.sv
// Combinational N-bit Gray-to-binary decoder.
module gray2bin_nbits
   import gray_pkg::*;
#(
   parameter int N = 5
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   assign bin = N'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_checker_nbits.sv
// Receive-side Gray stream checker: decodes each accepted sample, classifies
// the step against the previous sample and tracks lock with a saturating error count.
module gray_checker_nbits
   import gray_pkg::*;
#(
   parameter int N          = 5,
   parameter int ERR_LIMIT  = 3,
   parameter int LOCK_COUNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gray_valid,
   input  logic [N-1:0]     gray_in,
   output logic [N-1:0]     bin_out,
   output logic             bin_valid,
   output logic             step_ok,
   output logic             step_hold,
   output logic             step_err,
   output logic             locked,
   output logic [CNT_W-1:0] err_count
);

   localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   logic [N-1:0]      bin_p0;
   logic [N-1:0]      diff_p0;
   logic              is_ok_p0;
   logic              is_hold_p0;
   logic [N-1:0]      ref_p1;
   state_t            state_p1;
   logic [BAD_W-1:0]  bad_run_p1;
   logic [GOOD_W-1:0] good_run_p1;

   // Stage p0: decode and classify against the reference, modulo 2^N.
   gray2bin_nbits #(.N(N)) u_decode (
      .gray (gray_in),
      .bin  (bin_p0)
   );

   assign diff_p0    = bin_p0 - ref_p1;
   assign is_ok_p0   = (diff_p0 == N'(1));
   assign is_hold_p0 = (diff_p0 == '0);

   // Stage p1: registered results, lock FSM and counters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bin_out     <= '0;
         bin_valid   <= 1'b0;
         step_ok     <= 1'b0;
         step_hold   <= 1'b0;
         step_err    <= 1'b0;
         locked      <= 1'b0;
         err_count   <= '0;
         ref_p1      <= '0;
         state_p1    <= IDLE;
         bad_run_p1  <= '0;
         good_run_p1 <= '0;
      end else begin
         bin_valid <= gray_valid;
         if (gray_valid) begin
            bin_out <= bin_p0;
            ref_p1  <= bin_p0;
            if (state_p1 == IDLE) begin
               step_ok   <= 1'b0;
               step_hold <= 1'b0;
               step_err  <= 1'b0;
            end else begin
               step_ok   <= is_ok_p0;
               step_hold <= is_hold_p0;
               step_err  <= !is_ok_p0 && !is_hold_p0;
               if (!is_ok_p0 && !is_hold_p0) err_count <= sat_inc(err_count);
            end
            case (state_p1)
               IDLE: begin
                  state_p1    <= TRACK;
                  locked      <= 1'b1;
                  bad_run_p1  <= '0;
                  good_run_p1 <= '0;
               end
               TRACK: begin
                  if (is_ok_p0 || is_hold_p0) begin
                     bad_run_p1 <= '0;
                  end else if (bad_run_p1 == BAD_W'(ERR_LIMIT - 1)) begin
                     state_p1    <= LOST;
                     locked      <= 1'b0;
                     bad_run_p1  <= '0;
                     good_run_p1 <= '0;
                  end else begin
                     bad_run_p1 <= bad_run_p1 + BAD_W'(1);
                  end
               end
               LOST: begin
                  if (!is_ok_p0) begin
                     good_run_p1 <= '0;
                  end else if (good_run_p1 == GOOD_W'(LOCK_COUNT - 1)) begin
                     state_p1    <= TRACK;
                     locked      <= 1'b1;
                     good_run_p1 <= '0;
                     bad_run_p1  <= '0;
                  end else begin
                     good_run_p1 <= good_run_p1 + GOOD_W'(1);
                  end
               end
               default: begin
                  state_p1 <= IDLE;
                  locked   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
